// File: rtl/tick_timer.sv
// Loadable down-counter timer paced by an asynchronous divided clock that is
// synchronised and edge-detected in the i_clk domain. Optional capture port set: TIMER_CAPTURE_EN.
module tick_timer #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_tick_src,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_value,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic             i_auto_reload,
`ifdef TIMER_CAPTURE_EN
  input  logic             i_capture,
  output logic [WIDTH-1:0] o_capture,
  output logic             o_capture_valid,
`endif
  output logic             o_tick,
  output logic [WIDTH-1:0] o_count,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_expired
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  logic             s1_q, s2_q, s3_q;
  logic             tick_q;
  logic             tick_int;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             expired_q, expired_d;

  // s1/s2 resolve metastability; s3 only delays s2 for rising-edge detection.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      s3_q   <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      s1_q   <= i_tick_src;
      s2_q   <= s1_q;
      s3_q   <= s2_q;
      tick_q <= tick_int;
    end
  end

  assign tick_int = s2_q & ~s3_q;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      reload_q  <= '0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      reload_q  <= reload_d;
      expired_q <= expired_d;
    end
  end

  // Strobe priority stop > load > start > tick; a stop outside RUN still
  // masks the lower-priority strobes for that cycle.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    reload_d  = reload_q;
    expired_d = 1'b0;

    if (i_stop) begin
      if (state_q == ST_RUN) begin
        state_d = ST_IDLE;
      end
    end else if (i_load) begin
      reload_d = i_load_value;
      count_d  = i_load_value;
      if (state_q == ST_DONE) begin
        state_d = ST_IDLE;
      end
    end else if (i_start && (state_q != ST_RUN)) begin
      if (state_q == ST_IDLE) begin
        if (count_q != '0) begin
          state_d = ST_RUN;
        end
      end else begin
        if (reload_q != '0) begin
          count_d = reload_q;
          state_d = ST_RUN;
        end
      end
    end else if ((state_q == ST_RUN) && tick_int) begin
      // A count of 0 in RUN (loaded while running) holds rather than wrapping.
      if (count_q > CNT_ONE) begin
        count_d = count_q - CNT_ONE;
      end else if (count_q == CNT_ONE) begin
        expired_d = 1'b1;
        if (i_auto_reload && (reload_q != '0)) begin
          count_d = reload_q;
        end else begin
          count_d = '0;
          state_d = ST_DONE;
        end
      end
    end
  end

`ifdef TIMER_CAPTURE_EN
  logic [WIDTH-1:0] capture_q, capture_d;
  logic             capture_valid_q, capture_valid_d;

  // Capture samples the pre-update count; a same-cycle capture wins over the clear.
  always_comb begin
    capture_d       = capture_q;
    capture_valid_d = capture_valid_q;
    if (i_load || i_start) begin
      capture_valid_d = 1'b0;
    end
    if (i_capture) begin
      capture_d       = count_q;
      capture_valid_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      capture_q       <= '0;
      capture_valid_q <= 1'b0;
    end else begin
      capture_q       <= capture_d;
      capture_valid_q <= capture_valid_d;
    end
  end

  assign o_capture       = capture_q;
  assign o_capture_valid = capture_valid_q;
`endif

  assign o_tick    = tick_q;
  assign o_count   = count_q;
  assign o_busy    = (state_q == ST_RUN);
  assign o_done    = (state_q == ST_DONE);
  assign o_expired = expired_q;

endmodule

// File: tb/tb_tick_timer.sv
// Directed bench for tick_timer (WIDTH=8) with a divide-by-6 source model and
// a scoreboard of expected o_tick cycles.
module tb_tick_timer;

  localparam int unsigned W = 8;

  logic         i_clk;
  logic         i_rst;
  logic         i_tick_src;
  logic         i_load;
  logic [W-1:0] i_load_value;
  logic         i_start;
  logic         i_stop;
  logic         i_auto_reload;
  logic         o_tick;
  logic [W-1:0] o_count;
  logic         o_busy;
  logic         o_done;
  logic         o_expired;
`ifdef TIMER_CAPTURE_EN
  logic         i_capture;
  logic [W-1:0] o_capture;
  logic         o_capture_valid;
`endif

  tick_timer #(.WIDTH(W)) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_tick_src     (i_tick_src),
    .i_load         (i_load),
    .i_load_value   (i_load_value),
    .i_start        (i_start),
    .i_stop         (i_stop),
    .i_auto_reload  (i_auto_reload),
`ifdef TIMER_CAPTURE_EN
    .i_capture      (i_capture),
    .o_capture      (o_capture),
    .o_capture_valid(o_capture_valid),
`endif
    .o_tick         (o_tick),
    .o_count        (o_count),
    .o_busy         (o_busy),
    .o_done         (o_done),
    .o_expired      (o_expired)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int ntick = 0;
  int nexp = 0;
  int last_tick = 0;
  int div_cnt = 0;
  logic div_en = 1'b0;
  int tq[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // One negedge: score o_tick against the queue, then advance the divider model.
  task automatic step();
    @(negedge i_clk);
    cyc++;
    if (o_tick) begin
      ntick++;
      if (tq.size() == 0) check("tick_unexpected", 32'(cyc), 32'(0));
      else check("tick_time", 32'(cyc), 32'(tq.pop_front()));
      if (last_tick > 0) check("tick_spacing", 32'(cyc - last_tick), 32'(6));
      last_tick = cyc;
    end
    if (tq.size() > 0 && tq[0] < cyc) begin
      check("tick_missed", 32'(tq[0]), 32'(cyc));
      void'(tq.pop_front());
    end
    if (o_expired) nexp++;
    if (!i_rst || !div_en) begin
      div_cnt    = 0;
      i_tick_src = 1'b0;
    end else begin
      div_cnt++;
      if (div_cnt == 3) begin
        div_cnt    = 0;
        i_tick_src = ~i_tick_src;
        if (i_tick_src) tq.push_back(cyc + 3);
      end
    end
  endtask

  task automatic wait_tick();
    int n0;
    n0 = ntick;
    for (int i = 0; i < 20 && ntick == n0; i++) step();
    check("tick_timeout", 32'(ntick - n0), 32'(1));
  endtask

  // Returns at the negedge just before the posedge on which tick_int is high.
  task automatic pre_tick();
    int found;
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      step();
      if (tq.size() > 0 && tq[0] == cyc + 1) found = 1;
    end
    check("pretick_timeout", 32'(found), 32'(1));
  endtask

  task automatic strobe_load(input logic [W-1:0] v);
    i_load = 1'b1; i_load_value = v; step(); i_load = 1'b0;
  endtask

  task automatic strobe_start();
    i_start = 1'b1; step(); i_start = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_tick"},    32'(o_tick),    32'(0));
    check({tag, "_count"},   32'(o_count),   32'(0));
    check({tag, "_busy"},    32'(o_busy),    32'(0));
    check({tag, "_done"},    32'(o_done),    32'(0));
    check({tag, "_expired"}, 32'(o_expired), 32'(0));
`ifdef TIMER_CAPTURE_EN
    check({tag, "_cap"},     32'(o_capture),       32'(0));
    check({tag, "_capv"},    32'(o_capture_valid), 32'(0));
`endif
  endtask

  initial begin
    int e0;
    i_rst = 1'b0; i_tick_src = 1'b0; i_load = 1'b0; i_load_value = '0;
    i_start = 1'b0; i_stop = 1'b0; i_auto_reload = 1'b0;
`ifdef TIMER_CAPTURE_EN
    i_capture = 1'b0;
`endif
    step(); step(); step();
    check_all_zero("reset");
    i_rst = 1'b1;
    div_en = 1'b1;

    // Tick timing: the scoreboard scores each pulse while idling.
    for (int i = 0; i < 30; i++) step();
    check("tick_count_ge4", 32'(ntick >= 4), 32'(1));

    // One-shot from 3.
    strobe_load(8'd3);
    check("os_load_count", 32'(o_count), 32'(3));
    check("os_load_busy", 32'(o_busy), 32'(0));
    strobe_start();
    check("os_start_busy", 32'(o_busy), 32'(1));
    e0 = nexp;
    wait_tick(); check("os_count2", 32'(o_count), 32'(2));
    wait_tick(); check("os_count1", 32'(o_count), 32'(1));
    check("os_noexp_yet", 32'(nexp - e0), 32'(0));
    wait_tick();
    check("os_count0", 32'(o_count), 32'(0));
    check("os_expired", 32'(o_expired), 32'(1));
    check("os_busy", 32'(o_busy), 32'(0));
    check("os_done", 32'(o_done), 32'(1));
    step();
    check("os_exp_width", 32'(o_expired), 32'(0));
    wait_tick(); wait_tick();
    check("os_hold0", 32'(o_count), 32'(0));
    check("os_done_hold", 32'(o_done), 32'(1));
    check("os_exp_once", 32'(nexp - e0), 32'(1));

    // Auto-reload with period 2, five periods.
    strobe_load(8'd2);
    check("ar_load_idle", 32'(o_done), 32'(0));
    i_auto_reload = 1'b1;
    strobe_start();
    e0 = nexp;
    for (int k = 1; k <= 10; k++) begin
      wait_tick();
      check("ar_count", 32'(o_count), (k % 2 == 1) ? 32'(1) : 32'(2));
      check("ar_expired", 32'(o_expired), (k % 2 == 1) ? 32'(0) : 32'(1));
      check("ar_done", 32'(o_done), 32'(0));
    end
    check("ar_exp_total", 32'(nexp - e0), 32'(5));
    i_auto_reload = 1'b0;

    // Priority: load in RUN, then stop coincident with a tick at 5.
    strobe_load(8'd9);
    check("pr_load_count", 32'(o_count), 32'(9));
    check("pr_load_busy", 32'(o_busy), 32'(1));
    for (int k = 8; k >= 5; k--) begin
      wait_tick();
      check("pr_dec", 32'(o_count), 32'(k));
    end
    pre_tick();
    i_stop = 1'b1; step(); i_stop = 1'b0;
    check("pr_stop_tick", 32'(o_tick), 32'(1));
    check("pr_stop_count", 32'(o_count), 32'(5));
    check("pr_stop_busy", 32'(o_busy), 32'(0));
    check("pr_stop_done", 32'(o_done), 32'(0));
    strobe_load(8'd0);
    strobe_start();
    check("pr_zero_busy", 32'(o_busy), 32'(0));
    check("pr_zero_done", 32'(o_done), 32'(0));
    check("pr_zero_count", 32'(o_count), 32'(0));

    // Asynchronous reset in RUN at count 4.
    strobe_load(8'd6);
    strobe_start();
    wait_tick(); wait_tick();
    check("rr_count4", 32'(o_count), 32'(4));
    check("rr_busy", 32'(o_busy), 32'(1));
    e0 = nexp;
    i_rst = 1'b0;
    #1;
    check_all_zero("rr_async");
    tq.delete();
    last_tick = 0;
    for (int i = 0; i < 4; i++) step();
    check("rr_no_exp", 32'(nexp - e0), 32'(0));
    i_rst = 1'b1;
    strobe_load(8'd1);
    strobe_start();
    wait_tick();
    check("rr_exp_first", 32'(o_expired), 32'(1));
    check("rr_count0", 32'(o_count), 32'(0));
    check("rr_done", 32'(o_done), 32'(1));

`ifdef TIMER_CAPTURE_EN
    // Capture coincident with a decrement from 7.
    strobe_load(8'd9);
    strobe_start();
    wait_tick(); wait_tick();
    check("cp_count7", 32'(o_count), 32'(7));
    pre_tick();
    i_capture = 1'b1; step(); i_capture = 1'b0;
    check("cp_count6", 32'(o_count), 32'(6));
    check("cp_value", 32'(o_capture), 32'(7));
    check("cp_valid", 32'(o_capture_valid), 32'(1));
    strobe_start();
    check("cp_clear", 32'(o_capture_valid), 32'(0));
    check("cp_hold", 32'(o_capture), 32'(7));
`endif

    step(); step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tick_timer.md
Name: tick_timer

Overview:
- Downstream consumer of the clock divider's o_clk. Treats the divided clock as a data signal in the fast i_clk domain, never as a clock.
- Synchronises the divided clock, edge-detects it into one-cycle ticks, and drives a loadable down-counter timer.
- Provides count, busy, done and expiry outputs for the CPU's timer/peripheral logic.

Parameters:
- WIDTH, 16, bit width of the counter, reload value and capture value.

Ports:
- i_clk  input  1  system clock; the fast clock that also feeds the divider.
- i_rst  input  1  asynchronous, active-low reset.
- i_tick_src  input  1  divided clock from the clock divider, asynchronous to this block's logic.
- i_load  input  1  one-cycle strobe: write i_load_value to the reload register and the counter.
- i_load_value  input  WIDTH  value written on i_load.
- i_start  input  1  one-cycle strobe: start counting.
- i_stop  input  1  one-cycle strobe: halt counting and hold the count.
- i_auto_reload  input  1  level input: on expiry, reload and keep running.
- o_tick  output  1  registered one-cycle pulse per rising edge of i_tick_src.
- o_count  output  WIDTH  current counter value.
- o_busy  output  1  high while in RUN.
- o_done  output  1  high while in DONE.
- o_expired  output  1  registered one-cycle pulse when the count reaches 0.

Behaviour:
- Reset (i_rst low, async): sync flops, o_tick, counter, reload register, o_expired all 0; state IDLE, so o_busy=0 and o_done=0.
- Synchroniser:
  - Two flops s1 and s2, then s3 delays s2; tick_int = s2 & ~s3; o_tick is tick_int registered.
  - Latency: o_tick is high on the 3rd i_clk rising edge after i_tick_src rises, for exactly 1 cycle.
  - i_tick_src high and low phases must each last at least 2 i_clk cycles. Divider DIVIDER>=1 meets this.
- Decrement uses tick_int, so the counter moves on the same edge that sets o_tick.
- States are IDLE, RUN, DONE. Strobe priority: stop > load > start > tick.
- i_stop:
  - RUN -> IDLE, counter held, no decrement even if a tick coincides.
  - Ignored in IDLE and DONE.
- i_load (any state, when no stop is present):
  - reload <= i_load_value and counter <= i_load_value.
  - DONE -> IDLE.
  - RUN stays RUN and continues from the new value. No decrement on that cycle.
- i_start:
  - IDLE: counter != 0 -> RUN; counter == 0 -> ignored, stay IDLE.
  - DONE: reload != 0 -> counter <= reload, go to RUN; else ignored.
  - RUN: ignored.
- RUN, tick_int high, no stop and no load:
  - counter > 1: counter <= counter - 1.
  - counter == 1: o_expired pulses next cycle. Then:
    - i_auto_reload high and reload != 0: counter <= reload, stay in RUN.
    - otherwise: counter <= 0 and RUN -> DONE.
- No wrap-around: the counter never decrements below 0.
- o_expired is 1 cycle wide, including in back-to-back auto-reload periods. With reload=1 and auto-reload, it pulses once per tick.
- Reset mid-RUN: immediate return to the reset values above; no o_expired pulse.
- All arithmetic is unsigned WIDTH-bit.

Optional Feature:
- Macro TIMER_CAPTURE_EN.
- Defined:
  - Adds ports i_capture (in, 1), o_capture (out, WIDTH) and o_capture_valid (out, 1).
  - On an i_capture strobe, o_capture <= counter value before any same-cycle update, and o_capture_valid <= 1.
  - o_capture_valid clears on the next i_load or i_start.
  - Both capture outputs reset to 0.
- Not defined: these ports and registers are absent and all other behaviour is identical.

Test Plan:
- Reset and tick timing: WIDTH=8; i_tick_src from a divider model, period 6 i_clk. Check o_tick pulses 1 cycle wide, 3 cycles after each rising edge, 6 cycles apart. All outputs are 0 during reset.
- One-shot: load 3, start. o_count steps 3->2->1->0 on ticks; o_expired pulses once; o_busy falls, o_done rises; further ticks leave the count at 0.
- Auto-reload: load 2, i_auto_reload=1, start. o_expired pulses every 2nd tick for 5 periods; o_done stays 0.
- Priority: stop coincident with a tick at count 5 -> count stays 5, state IDLE. Load 9 while in RUN -> count 9, still RUN. Start with count 0 in IDLE -> stays IDLE.
- Async reset mid-RUN at count 4 -> all outputs 0 immediately, with no o_expired pulse. Load 1 and start after reset -> o_expired on the first tick.
- TIMER_CAPTURE_EN: capture at count 7 coincident with a decrement -> o_capture=7, o_capture_valid=1. Next i_start -> o_capture_valid=0.
